reset_sequencer: RTL and testbench

Parametrised board-level reset controller that sits between the clock wizard and the SoC in every FPGA top. It synchronises the PLL `locked` flag, waits for the lock to be stable, then releases NUM_DOMAINS reset outputs one after another (memory controller, interconnect, core, peripherals). It re-sequences on lock loss or on a soft-reset request and keeps a saturating lock-loss counter for firmware diagnostics.

---
 rtl/reset_seq_pkg.sv | 16 +
 rtl/sync_ff.sv | 27 ++
 rtl/reset_sequencer.sv | 189 ++++++++++++++++++
 tb/tb_reset_sequencer.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and constants for the board-level reset sequencer.
//   rst_state_t : sequencer FSM states
//   LOSS_MAX    : saturation value of the lock-loss counter
package reset_seq_pkg;

    typedef enum logic [2:0] {
        WAIT_LOCK = 3'd0,
        STABILIZE = 3'd1,
        RELEASE   = 3'd2,
        RUN       = 3'd3,
        SOFT_HOLD = 3'd4
    } rst_state_t;

    localparam logic [7:0] LOSS_MAX = 8'd255;

endpackage

// File: rtl/sync_ff.sv
// Multi-stage synchroniser for a single asynchronous level.
//   clk   : destination clock
//   rst_n : asynchronous active-low reset, clears every stage to 0
//   d     : asynchronous input
//   q     : synchronised output, STAGES clk edges of latency
module sync_ff #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr <= '0;
        end else begin
            sr <= {sr[STAGES-2:0], d};
        end
    end

    assign q = sr[STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Board-level reset controller: synchronises the PLL lock flag, waits for a
// stable lock, then releases NUM_DOMAINS active-low resets one after another.
// Re-sequences on lock loss or a soft-reset request; counts lock losses.
//   clk          : user clock
//   rst_n        : asynchronous active-low reset
//   pll_locked   : asynchronous PLL lock flag
//   soft_rst_req : asynchronous soft-reset request level
//   clear_status : synchronous pulse clearing loss_count
//   domain_rst_n : staged active-low domain resets, bit 0 released first
//   sys_ready    : high only while all domains run
//   loss_count   : saturating count of lock-loss events
module reset_sequencer
    import reset_seq_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ         = 100_000_000,
    parameter int unsigned NUM_DOMAINS        = 3,
    parameter int unsigned LOCK_STABLE_CYCLES = 1024,
    parameter int unsigned STAGE_DELAY_CYCLES = 256,
    parameter int unsigned SOFT_RST_CYCLES    = 16,
    parameter int unsigned SYNC_STAGES        = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   pll_locked,
    input  logic                   soft_rst_req,
    input  logic                   clear_status,
    output logic [NUM_DOMAINS-1:0] domain_rst_n,
    output logic                   sys_ready,
    output logic [7:0]             loss_count
);

    localparam int unsigned MAX_LS = (LOCK_STABLE_CYCLES > STAGE_DELAY_CYCLES)
                                   ? LOCK_STABLE_CYCLES : STAGE_DELAY_CYCLES;
    localparam int unsigned MAX_CNT = (MAX_LS > SOFT_RST_CYCLES) ? MAX_LS : SOFT_RST_CYCLES;
    localparam int unsigned CW = $clog2(MAX_CNT + 1);
    localparam int unsigned SW = $clog2(NUM_DOMAINS + 1);

    localparam logic [CW-1:0] LOCK_LAST  = CW'(LOCK_STABLE_CYCLES - 1);
    localparam logic [CW-1:0] STAGE_LAST = CW'(STAGE_DELAY_CYCLES - 1);
    localparam logic [CW-1:0] SOFT_LAST  = CW'(SOFT_RST_CYCLES - 1);
    localparam logic [SW-1:0] DOM_LAST   = SW'(NUM_DOMAINS - 1);

    if (CLOCK_FREQ < 1) begin : g_bad_freq
        $error("reset_sequencer: CLOCK_FREQ must be non-zero");
    end
    if (NUM_DOMAINS < 1 || NUM_DOMAINS > 8) begin : g_bad_domains
        $error("reset_sequencer: NUM_DOMAINS must be 1..8");
    end
    if (LOCK_STABLE_CYCLES < 1 || STAGE_DELAY_CYCLES < 1 || SOFT_RST_CYCLES < 1) begin : g_bad_cycles
        $error("reset_sequencer: cycle counts must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("reset_sequencer: SYNC_STAGES must be >= 2");
    end

    logic locked_s, soft_s, soft_prev, soft_rise;

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_lock (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (pll_locked),
        .q     (locked_s)
    );

    sync_ff #(.STAGES(SYNC_STAGES)) u_sync_soft (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (soft_rst_req),
        .q     (soft_s)
    );

    assign soft_rise = soft_s & ~soft_prev;

    rst_state_t             state, state_n;
    logic [CW-1:0]          cnt, cnt_n;
    logic [SW-1:0]          stage, stage_n;
    logic                   loss_evt;
    logic [NUM_DOMAINS-1:0] dom_n;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= WAIT_LOCK;
            cnt          <= '0;
            stage        <= '0;
            soft_prev    <= 1'b0;
            domain_rst_n <= '0;
            sys_ready    <= 1'b0;
            loss_count   <= '0;
        end else begin
            state        <= state_n;
            cnt          <= cnt_n;
            stage        <= stage_n;
            soft_prev    <= soft_s;
            domain_rst_n <= dom_n;
            sys_ready    <= (state_n == RUN);
            if (clear_status) begin
                loss_count <= '0;
            end else if (loss_evt && loss_count != LOSS_MAX) begin
                loss_count <= loss_count + 8'd1;
            end
        end
    end

    // Lock loss is tested before soft_rise in every state so it always wins.
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        stage_n  = stage;
        loss_evt = 1'b0;
        case (state)
            WAIT_LOCK: begin
                cnt_n   = '0;
                stage_n = '0;
                if (locked_s) state_n = STABILIZE;
            end
            STABILIZE: begin
                if (!locked_s) begin
                    state_n = WAIT_LOCK;
                    cnt_n   = '0;
                end else if (cnt == LOCK_LAST) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    stage_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RELEASE: begin
                if (!locked_s) begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    stage_n  = '0;
                    loss_evt = 1'b1;
                end else if (soft_rise) begin
                    state_n = SOFT_HOLD;
                    cnt_n   = '0;
                    stage_n = '0;
                end else if (cnt == STAGE_LAST) begin
                    cnt_n = '0;
                    if (stage == DOM_LAST) state_n = RUN;
                    else                   stage_n = stage + 1'b1;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            RUN: begin
                if (!locked_s) begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    stage_n  = '0;
                    loss_evt = 1'b1;
                end else if (soft_rise) begin
                    state_n = SOFT_HOLD;
                    cnt_n   = '0;
                    stage_n = '0;
                end
            end
            SOFT_HOLD: begin
                if (!locked_s) begin
                    state_n  = WAIT_LOCK;
                    cnt_n    = '0;
                    stage_n  = '0;
                    loss_evt = 1'b1;
                end else if (cnt == SOFT_LAST) begin
                    state_n = RELEASE;
                    cnt_n   = '0;
                    stage_n = '0;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: begin
                state_n = WAIT_LOCK;
                cnt_n   = '0;
                stage_n = '0;
            end
        endcase
    end

    // Outputs are registered from the next-state view so they change on the
    // same edge as the state transition.
    always_comb begin
        dom_n = '0;
        for (int unsigned k = 0; k < NUM_DOMAINS; k++) begin
            dom_n[k] = (state_n == RUN) || ((state_n == RELEASE) && (SW'(k) <= stage_n));
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
module tb_reset_sequencer;

    typedef struct {
        int         cyc;
        logic [2:0] dom;
        logic       rdy;
        logic [7:0] loss;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       pll_locked = 1'b0;
    logic       soft_rst_req = 1'b0;
    logic       clear_status = 1'b0;
    logic [2:0] domain_rst_n;
    logic       sys_ready;
    logic [7:0] loss_count;

    int    cyc = 0;
    int    n_checks = 0;
    int    n_fail = 0;
    int    exp_loss = 0;
    exp_t  sb[$];
    string sb_name[$];

    reset_sequencer #(
        .CLOCK_FREQ         (100_000_000),
        .NUM_DOMAINS        (3),
        .LOCK_STABLE_CYCLES (8),
        .STAGE_DELAY_CYCLES (4),
        .SOFT_RST_CYCLES    (5),
        .SYNC_STAGES        (2)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .pll_locked   (pll_locked),
        .soft_rst_req (soft_rst_req),
        .clear_status (clear_status),
        .domain_rst_n (domain_rst_n),
        .sys_ready    (sys_ready),
        .loss_count   (loss_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end

    task automatic push(input int c, input logic [2:0] d, input logic r, input string nm);
        exp_t e;
        e.cyc  = c;
        e.dom  = d;
        e.rdy  = r;
        e.loss = 8'(exp_loss);
        sb.push_back(e);
        sb_name.push_back(nm);
    endtask

    // Expected power-up milestones relative to edge E (first edge sampling lock=1).
    task automatic powerup_expect(input int e);
        push(e + 9,  3'b000, 1'b0, "pu_before_d0");
        push(e + 10, 3'b001, 1'b0, "pu_d0");
        push(e + 13, 3'b001, 1'b0, "pu_before_d1");
        push(e + 14, 3'b011, 1'b0, "pu_d1");
        push(e + 17, 3'b011, 1'b0, "pu_before_d2");
        push(e + 18, 3'b111, 1'b0, "pu_d2");
        push(e + 21, 3'b111, 1'b0, "pu_before_ready");
        push(e + 22, 3'b111, 1'b1, "pu_ready");
    endtask

    task automatic scoreboard_monitor();
        exp_t  e;
        string nm;
        forever begin
            @(negedge clk);
            while (sb.size() != 0 && sb[0].cyc <= cyc) begin
                e  = sb.pop_front();
                nm = sb_name.pop_front();
                n_checks++;
                if (e.cyc != cyc) begin
                    n_fail++;
                    $display("FAIL %s: expectation for cycle %0d missed, now cycle %0d", nm, e.cyc, cyc);
                end else if ({domain_rst_n, sys_ready, loss_count} !== {e.dom, e.rdy, e.loss}) begin
                    n_fail++;
                    $display("FAIL %s @cyc %0d: got dom=%b rdy=%b loss=%0d, expected dom=%b rdy=%b loss=%0d",
                             nm, cyc, domain_rst_n, sys_ready, loss_count, e.dom, e.rdy, e.loss);
                end
            end
        end
    endtask

    task automatic wait_drain(input int budget, input string nm);
        for (int i = 0; i < budget && sb.size() != 0; i++) @(negedge clk);
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL %s_drain: %0d expectations left after %0d cycles, expected 0", nm, sb.size(), budget);
            sb.delete();
            sb_name.delete();
        end
    endtask

    // One lock-up / lock-loss cycle with the increment landing in RELEASE.
    task automatic lock_event(input bit clr_at_inc);
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (12) @(negedge clk);
        pll_locked = 1'b0;
        repeat (2) @(negedge clk);
        if (clr_at_inc) clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        if (clr_at_inc)          exp_loss = 0;
        else if (exp_loss < 255) exp_loss++;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if ({domain_rst_n, sys_ready, loss_count} !== 12'h000) begin
            n_fail++;
            $display("FAIL reset_values: got dom=%b rdy=%b loss=%0d, expected all 0", domain_rst_n, sys_ready, loss_count);
        end
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        n_checks++;
        if ({domain_rst_n, sys_ready} !== 4'b0000) begin
            n_fail++;
            $display("FAIL idle_unlocked: got dom=%b rdy=%b, expected 000/0", domain_rst_n, sys_ready);
        end
    endtask

    task automatic test_power_up();
        @(negedge clk);
        pll_locked = 1'b1;
        powerup_expect(cyc + 1);
        wait_drain(60, "power_up");
    endtask

    task automatic test_soft_run();
        int s;
        @(negedge clk);
        soft_rst_req = 1'b1;
        s = cyc + 1;
        push(s + 1,  3'b111, 1'b1, "soft_still_run");
        push(s + 2,  3'b000, 1'b0, "soft_hold");
        push(s + 6,  3'b000, 1'b0, "soft_before_d0");
        push(s + 7,  3'b001, 1'b0, "soft_d0");
        push(s + 11, 3'b011, 1'b0, "soft_d1");
        push(s + 15, 3'b111, 1'b0, "soft_d2");
        push(s + 18, 3'b111, 1'b0, "soft_before_ready");
        push(s + 19, 3'b111, 1'b1, "soft_ready");
        wait_drain(60, "soft_run");
        soft_rst_req = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_lock_loss_run();
        int f;
        @(negedge clk);
        pll_locked = 1'b0;
        f = cyc + 1;
        push(f + 1, 3'b111, 1'b1, "loss_still_run");
        exp_loss++;
        push(f + 2, 3'b000, 1'b0, "loss_all_low");
        push(f + 5, 3'b000, 1'b0, "loss_held");
        wait_drain(30, "lock_loss");
        @(negedge clk);
        pll_locked = 1'b1;
        powerup_expect(cyc + 1);
        wait_drain(60, "relock");
    endtask

    task automatic test_glitch();
        int e0;
        @(negedge clk);
        pll_locked = 1'b0;
        exp_loss++;
        repeat (5) @(negedge clk);
        pll_locked = 1'b1;
        e0 = cyc + 1;
        push(e0 + 10, 3'b000, 1'b0, "glitch_no_early_release");
        repeat (5) @(negedge clk);
        pll_locked = 1'b0;
        @(negedge clk);
        pll_locked = 1'b1;
        powerup_expect(cyc + 1);
        wait_drain(60, "glitch");
        n_checks++;
        if (loss_count !== 8'(exp_loss)) begin
            n_fail++;
            $display("FAIL glitch_loss_count: got %0d, expected %0d", loss_count, exp_loss);
        end
    endtask

    task automatic test_simultaneous();
        int f;
        @(negedge clk);
        pll_locked   = 1'b0;
        soft_rst_req = 1'b1;
        f = cyc + 1;
        exp_loss++;
        push(f + 2, 3'b000, 1'b0, "simul_wait_lock");
        push(f + 3, 3'b000, 1'b0, "simul_single_inc");
        push(f + 8, 3'b000, 1'b0, "simul_no_soft_release");
        wait_drain(30, "simultaneous");
        soft_rst_req = 1'b0;
        repeat (3) @(negedge clk);
        pll_locked = 1'b1;
        powerup_expect(cyc + 1);
        wait_drain(60, "simul_relock");
    endtask

    task automatic test_saturation();
        @(negedge clk);
        pll_locked = 1'b0;
        exp_loss++;
        repeat (4) @(negedge clk);
        for (int i = 0; i < 300; i++) begin
            lock_event(1'b0);
            n_checks++;
            if (loss_count !== 8'(exp_loss)) begin
                n_fail++;
                $display("FAIL sat_step%0d: got loss=%0d, expected %0d", i, loss_count, exp_loss);
            end
        end
        n_checks++;
        if (loss_count !== 8'd255) begin
            n_fail++;
            $display("FAIL sat_final: got loss=%0d, expected 255", loss_count);
        end
    endtask

    task automatic test_clear();
        @(negedge clk);
        clear_status = 1'b1;
        @(negedge clk);
        clear_status = 1'b0;
        exp_loss = 0;
        n_checks++;
        if (loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_pulse: got loss=%0d, expected 0", loss_count);
        end
        lock_event(1'b0);
        n_checks++;
        if (loss_count !== 8'd1) begin
            n_fail++;
            $display("FAIL post_clear_inc: got loss=%0d, expected 1", loss_count);
        end
        lock_event(1'b1);
        n_checks++;
        if (loss_count !== 8'd0) begin
            n_fail++;
            $display("FAIL clear_with_inc: got loss=%0d, expected 0", loss_count);
        end
    endtask

    task automatic test_reset_mid();
        lock_event(1'b0);
        @(negedge clk);
        pll_locked = 1'b1;
        repeat (16) @(negedge clk);
        n_checks++;
        if (domain_rst_n !== 3'b011) begin
            n_fail++;
            $display("FAIL mid_stage1: got dom=%b, expected 011", domain_rst_n);
        end
        rst_n = 1'b0;
        #1;
        n_checks++;
        if ({domain_rst_n, sys_ready, loss_count} !== 12'h000) begin
            n_fail++;
            $display("FAIL mid_async_reset: got dom=%b rdy=%b loss=%0d, expected all 0",
                     domain_rst_n, sys_ready, loss_count);
        end
        exp_loss = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        powerup_expect(cyc + 1);
        wait_drain(60, "reset_mid");
    endtask

    initial begin
        fork
            scoreboard_monitor();
        join_none
        test_reset();
        test_power_up();
        test_soft_run();
        test_lock_loss_run();
        test_glitch();
        test_simultaneous();
        test_saturation();
        test_clear();
        test_reset_mid();
        repeat (2) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
